psram_rd_capture_seq: RTL and testbench
=======================================

Name: psram_rd_capture_seq

Overview:
- Sequences the IDDR-based PSRAM read datapath.
- After the command phase, waits a programmed latency, then samples the IDDR Q0/Q1 byte pairs for a programmed burst length and packs each pair into a 16-bit word.
- Buffers captured words in a small FIFO with a valid/ready interface toward the PSRAM controller core.
- Sits between the IDDR primitives on DQ[7:0] and the PSRAM controller's read-return path.

Parameters:
- DQ_W, 8: width of each IDDR output (Q0 and Q1).
- LAT_W, 4: width of the latency field.
- BURST_W, 5: width of the burst-length field.
- FIFO_DEPTH, 4: capture FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; same clock as the IDDR CLK.
- reset_n  in  1  synchronous reset, active low.
- start  in  1  single-cycle request to begin a read capture.
- latency  in  LAT_W  cycles to wait after start before the first capture; sampled with start.
- burst_len  in  BURST_W  number of 16-bit words to capture; sampled with start.
- iddr_q0  in  DQ_W  IDDR Q0, the first (rising-edge) byte.
- iddr_q1  in  DQ_W  IDDR Q1, the second (falling-edge) byte.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the transaction completes.
- rd_data  out  2*DQ_W  FIFO head word: {q0, q1}, with q0 in the upper byte.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts rd_data when rd_valid && rd_ready.
- overflow  out  1  sticky: a captured word was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - busy=0, done=0, rd_valid=0, overflow=0, rd_data=0.
  - FIFO pointers are cleared.
  - Reset mid-transaction aborts immediately; no done pulse is produced.
- States: IDLE, WAIT_LAT, CAPTURE, DONE.
- IDLE:
  - start=1 at edge T0 latches latency and burst_len, clears overflow and sets busy=1.
  - Next state is WAIT_LAT if latency>0.
  - Otherwise next state is CAPTURE if burst_len>0, else DONE.
- start while busy=1 is ignored, with no side effects.
- WAIT_LAT: the counter decrements each edge. At the edge where it reaches 0, go to CAPTURE (or DONE if burst_len=0).
- CAPTURE:
  - Samples {iddr_q0, iddr_q1} on each of burst_len consecutive edges.
  - The first sample is taken at edge T0+latency+1; the last at T0+latency+burst_len.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then return to IDLE. A start in the DONE cycle is ignored.
- FIFO behaviour:
  - A captured word is written at its sample edge; rd_valid rises on the following cycle.
  - Show-ahead: rd_data is valid whenever rd_valid=1.
  - A pop happens on any edge with rd_valid && rd_ready.
  - Push and pop on the same edge are both performed, including when the FIFO is full; occupancy is unchanged and no overflow occurs.
  - A push when full with no simultaneous pop drops the new word, sets overflow=1 and leaves FIFO contents unchanged.
  - The capture count still advances on a dropped word. PSRAM cannot be stalled.
  - Pointers wrap modulo FIFO_DEPTH.
- rd_data holds its value when rd_valid=0; the value is don't-care to consumers.
- The FIFO continues to drain after done; it is not flushed at start.

Optional Feature:
- Macro: PSRAM_RWDS_GATE_EN.
- When defined:
  - Adds inputs rwds_q0 and rwds_q1 (1 bit each, from a second IDDR on RWDS).
  - Adds output timeout (1 bit, sticky, cleared on an accepted start).
  - In CAPTURE, a word is sampled only on edges where rwds_q0=1 and rwds_q1=0. Other edges do not advance the word count.
  - 16 consecutive CAPTURE edges without a valid strobe set timeout=1 and force DONE.
- When not defined: fixed-latency capture as described above; none of these ports exist.

Test Plan:
- Fixed latency: reset, then start with latency=3, burst_len=4, rd_ready=1, and q0/q1 pairs 0x12/0x34, 0x56/0x78, 0x9A/0xBC, 0xDE/0xF0 driven at T0+4..T0+7.
  - rd_data must be 0x1234, 0x5678, 0x9ABC, 0xDEF0 at T0+5..T0+8.
  - done must pulse at T0+8; overflow must stay 0.
- Zero cases:
  - latency=0, burst_len=2: first sample at T0+1, done at T0+3.
  - latency=5, burst_len=0: no rd_valid, done at T0+6.
- Backpressure: rd_ready=0, burst_len=6, FIFO_DEPTH=4.
  - Words 1-4 must be retained, words 5-6 dropped, overflow=1.
  - After rd_ready=1, exactly 4 words must drain in order.
  - A new start must clear overflow.
- Full with simultaneous pop: FIFO full and rd_ready=1 during capture.
  - No word may be lost and overflow must stay 0.
- Start while busy, and reset mid-CAPTURE:
  - A second start while busy is ignored; the transaction length is unchanged.
  - reset_n=0 mid-CAPTURE gives busy=0, rd_valid=0 and no done pulse on the next cycle.
- PSRAM_RWDS_GATE_EN:
  - A strobe valid only on alternate cycles for burst_len=3 must capture 3 words over 6 edges.
  - RWDS held low must give timeout=1 and done after 16 edges.

Source files
------------

// File: rtl/psram_rd_capture_seq.sv
// PSRAM read capture sequencer: latency wait, IDDR byte-pair packing, show-ahead capture FIFO.
// Optional RWDS strobe gating with capture timeout is enabled by defining PSRAM_RWDS_GATE_EN.
module psram_rd_capture_seq #(
  parameter int DQ_W       = 8,
  parameter int LAT_W      = 4,
  parameter int BURST_W    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LAT_W-1:0]     latency,
  input  logic [BURST_W-1:0]   burst_len,
  input  logic [DQ_W-1:0]      iddr_q0,
  input  logic [DQ_W-1:0]      iddr_q1,
`ifdef PSRAM_RWDS_GATE_EN
  input  logic                 rwds_q0,
  input  logic                 rwds_q1,
  output logic                 timeout,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*DQ_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LAT,
    CAPTURE,
    DONE
  } state_t;

  state_t               state;
  logic [LAT_W-1:0]     lat_cnt;
  logic [BURST_W-1:0]   word_cnt;

  logic [2*DQ_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;

  logic                 strobe;
  logic                 start_acc;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic [2*DQ_W-1:0]    cap_word;

`ifdef PSRAM_RWDS_GATE_EN
  logic [3:0]           miss_cnt;
`endif

  always_comb begin
`ifdef PSRAM_RWDS_GATE_EN
    strobe = rwds_q0 & ~rwds_q1;
`else
    strobe = 1'b1;
`endif
  end

  assign start_acc = (state == IDLE) && start;
  assign push      = (state == CAPTURE) && strobe;
  assign rd_valid  = (count != '0);
  assign pop       = rd_valid && rd_ready;
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  // a full FIFO still accepts a word when the head leaves on the same edge
  assign push_ok   = push && (!full || pop);
  assign cap_word  = {iddr_q0, iddr_q1};
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      word_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PSRAM_RWDS_GATE_EN
      miss_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lat_cnt  <= latency;
            word_cnt <= burst_len;
`ifdef PSRAM_RWDS_GATE_EN
            miss_cnt <= '0;
            timeout  <= 1'b0;
`endif
            if (latency != '0) begin
              state <= WAIT_LAT;
              busy  <= 1'b1;
            end else if (burst_len != '0) begin
              state <= CAPTURE;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        WAIT_LAT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            if (word_cnt != '0) begin
              state <= CAPTURE;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          // dropped words still count: the PSRAM side cannot be stalled
          if (strobe) begin
            word_cnt <= word_cnt - 1'b1;
`ifdef PSRAM_RWDS_GATE_EN
            miss_cnt <= '0;
`endif
            if (word_cnt == BURST_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
`ifdef PSRAM_RWDS_GATE_EN
          else if (miss_cnt == 4'd15) begin
            timeout <= 1'b1;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            miss_cnt <= miss_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= cap_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (start_acc) begin
        overflow <= 1'b0;
      end else if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psram_rd_capture_seq.sv
// Directed self-checking bench for psram_rd_capture_seq; RWDS cases built when PSRAM_RWDS_GATE_EN is set.
module tb_psram_rd_capture_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  latency;
  logic [4:0]  burst_len;
  logic [7:0]  iddr_q0;
  logic [7:0]  iddr_q1;
  logic        busy;
  logic        done;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        overflow;
`ifdef PSRAM_RWDS_GATE_EN
  logic        rwds_q0;
  logic        rwds_q1;
  logic        timeout;
`endif

  int          total;
  int          bad;
  int          n_pop;
  logic [15:0] exp_q [$];

  psram_rd_capture_seq #(
    .DQ_W(8), .LAT_W(4), .BURST_W(5), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .latency(latency),
    .burst_len(burst_len),
    .iddr_q0(iddr_q0),
    .iddr_q1(iddr_q1),
`ifdef PSRAM_RWDS_GATE_EN
    .rwds_q0(rwds_q0),
    .rwds_q1(rwds_q1),
    .timeout(timeout),
`endif
    .busy(busy),
    .done(done),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Scores any pop about to happen at the next edge, then advances one cycle.
  task automatic step();
    if (rd_valid && rd_ready) begin
      n_pop++;
      if (exp_q.size() == 0) check("unexp_pop", {31'd0, rd_valid}, 32'd0);
      else                   check("pop_word", {16'd0, rd_data}, {16'd0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] lat, input logic [4:0] bl);
    start     = 1'b1;
    latency   = lat;
    burst_len = bl;
    step();
    start     = 1'b0;
  endtask

  task automatic drive_word(input logic [15:0] w, input bit keep);
    iddr_q0 = w[15:8];
    iddr_q1 = w[7:0];
    if (keep) exp_q.push_back(w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t1 [4];
    int          np0;
    t1[0] = 16'h1234; t1[1] = 16'h5678; t1[2] = 16'h9ABC; t1[3] = 16'hDEF0;
    total = 0; bad = 0; n_pop = 0;
    reset_n = 1'b0; start = 1'b0; latency = '0; burst_len = '0;
    iddr_q0 = 8'hAA; iddr_q1 = 8'h55; rd_ready = 1'b0;
`ifdef PSRAM_RWDS_GATE_EN
    rwds_q0 = 1'b1; rwds_q1 = 1'b0;
`endif
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", rd_data, 0);
    reset_n = 1'b1;
    step();

    // fixed latency 3, burst 4
    rd_ready = 1'b1;
    do_start(4'd3, 5'd4);
    check("t1_busy", busy, 1);
    repeat (3) step();
    check("t1_no_early", rd_valid, 0);
    for (int i = 0; i < 4; i++) begin
      drive_word(t1[i], 1'b1);
      step();
      if (i == 0) begin
        check("t1_first_valid", rd_valid, 1);
        check("t1_first_data", rd_data, 16'h1234);
      end
      if (i < 3) check("t1_no_done", done, 0);
    end
    check("t1_done", done, 1);
    check("t1_busy_off", busy, 0);
    drive_word(16'hAA55, 1'b0);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_empty", rd_valid, 0);
    check("t1_ovf", overflow, 0);

    // latency 0, burst 2
    do_start(4'd0, 5'd2);
    drive_word(16'h1122, 1'b1);
    step();
    check("z1_valid", rd_valid, 1);
    check("z1_busy", busy, 1);
    drive_word(16'h3344, 1'b1);
    step();
    check("z1_done", done, 1);
    step();
    check("z1_done_off", done, 0);

    // latency 5, burst 0
    do_start(4'd5, 5'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("z2_wait", done, 0);
    end
    step();
    check("z2_done", done, 1);
    check("z2_no_valid", rd_valid, 0);
    step();

    // backpressure, burst 6 into depth 4
    rd_ready = 1'b0;
    do_start(4'd0, 5'd6);
    for (int i = 0; i < 6; i++) begin
      drive_word(16'hA001 + 16'(i), i < 4);
      step();
    end
    check("bp_done", done, 1);
    check("bp_ovf", overflow, 1);
    check("bp_head", rd_data, 16'hA001);
    rd_ready = 1'b1;
    np0 = n_pop;
    repeat (5) step();
    check("bp_npop", n_pop - np0, 4);
    check("bp_empty", rd_valid, 0);
    do_start(4'd2, 5'd0);
    check("bp_ovf_clr", overflow, 0);
    repeat (3) step();

    // full FIFO with simultaneous pop
    rd_ready = 1'b0;
    np0 = n_pop;
    do_start(4'd0, 5'd8);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) rd_ready = 1'b1;
      drive_word(16'hC000 + 16'(i), 1'b1);
      step();
    end
    check("fp_done", done, 1);
    check("fp_ovf", overflow, 0);
    repeat (5) step();
    check("fp_npop", n_pop - np0, 8);
    check("fp_empty", rd_valid, 0);

    // second start while busy is ignored
    do_start(4'd1, 5'd3);
    start = 1'b1; latency = 4'd7; burst_len = 5'd9;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_word(16'hB100 + 16'(i), 1'b1);
      step();
    end
    check("sb_done", done, 1);
    step();
    check("sb_idle", busy, 0);
    check("sb_empty", rd_valid, 0);

    // reset in the middle of capture
    rd_ready = 1'b0;
    do_start(4'd0, 5'd8);
    drive_word(16'hE001, 1'b0); step();
    drive_word(16'hE002, 1'b0); step();
    reset_n = 1'b0;
    step();
    check("mr_busy", busy, 0);
    check("mr_valid", rd_valid, 0);
    check("mr_done", done, 0);
    reset_n = 1'b1;
    step();
    check("mr_no_done", done, 0);
    check("mr_idle", busy, 0);

`ifdef PSRAM_RWDS_GATE_EN
    // strobe valid on alternate edges, burst 3
    rd_ready = 1'b1;
    np0 = n_pop;
    do_start(4'd0, 5'd3);
    for (int i = 0; i < 6; i++) begin
      rwds_q0 = (i % 2 == 1);
      drive_word(16'hD000 + 16'(i), i % 2 == 1);
      step();
      if (i == 4) check("rw_not_yet", done, 0);
    end
    check("rw_done", done, 1);
    check("rw_no_tmo", timeout, 0);
    rwds_q0 = 1'b1;
    repeat (2) step();
    check("rw_npop", n_pop - np0, 3);

    // RWDS stuck low
    rwds_q0 = 1'b0;
    do_start(4'd0, 5'd2);
    repeat (15) step();
    check("to_wait", done, 0);
    step();
    check("to_done", done, 1);
    check("to_flag", timeout, 1);
    check("to_nodata", rd_valid, 0);
    step();
    rwds_q0 = 1'b1;
    do_start(4'd1, 5'd0);
    check("to_clr", timeout, 0);
    repeat (3) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
